sa_ctrl: RTL and testbench

SA_CTRL -- requirements
Module: sa_ctrl

---
 rtl/sa_ctrl.sv | 87 ++++++++
 tb/tb_sa_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sa_ctrl.sv
// Sequencer for an N x N systolic array pass: weight load/shift, activation load,
// skewed compute with output capture, drain, then a one-cycle done pulse.
module sa_ctrl #(
    parameter int ARRAY_W = 4,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase,
    output logic       weight_buffer_load_en,
    output logic       weight_buffer_out_en,
    output logic       write_weight_en,
    output logic       input_buffer_load_en,
    output logic       input_buffer_out_en,
    output logic       output_buffer_load_en,
    output logic       output_buffer_out_en
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_LOAD  = 3'd1,
        S_W_SHIFT = 3'd2,
        S_A_LOAD  = 3'd3,
        S_COMPUTE = 3'd4,
        S_DRAIN   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LAST_N    = CNT_W'(ARRAY_W - 1);
    localparam logic [CNT_W-1:0] LAST_COMP = CNT_W'(3 * ARRAY_W - 2);
    // Results leave the array only during the last N compute cycles.
    localparam logic [CNT_W-1:0] OBL_FIRST = CNT_W'(2 * ARRAY_W - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        last_cnt = (state_q == S_COMPUTE) ? LAST_COMP : LAST_N;
        case (state_q)
            S_IDLE: begin
                // A simultaneous abort cancels the request before it starts.
                if (start && !abort) state_d = S_W_LOAD;
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == last_cnt) begin
                    state_d = state_t'(state_q + 3'd1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        busy                  = (state_q != S_IDLE);
        done                  = (state_q == S_DONE);
        phase                 = state_q;
        weight_buffer_load_en = (state_q == S_W_LOAD);
        weight_buffer_out_en  = (state_q == S_W_SHIFT);
        write_weight_en       = (state_q == S_W_SHIFT);
        input_buffer_load_en  = (state_q == S_A_LOAD);
        input_buffer_out_en   = (state_q == S_COMPUTE);
        output_buffer_load_en = (state_q == S_COMPUTE) && (cnt_q >= OBL_FIRST);
        output_buffer_out_en  = (state_q == S_DRAIN);
    end

endmodule

// File: tb/tb_sa_ctrl.sv
// Bench for sa_ctrl: a pass-timeline model compared every cycle, plus directed
// scenarios with literal latency and per-pass enable-count checks.
module tb_sa_ctrl;

    localparam int N    = 4;
    localparam int PASS = 7 * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done;
    logic [2:0] phase;
    logic       wbl, wbo, wwe, ibl, ibo, obl, obo;

    int checks = 0;
    int errors = 0;
    int pass_t = 0;
    int cyc = 0;
    int cnt_en [7];

    sa_ctrl #(.ARRAY_W(N), .CNT_W(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .abort                 (abort),
        .busy                  (busy),
        .done                  (done),
        .phase                 (phase),
        .weight_buffer_load_en (wbl),
        .weight_buffer_out_en  (wbo),
        .write_weight_en       (wwe),
        .input_buffer_load_en  (ibl),
        .input_buffer_out_en   (ibo),
        .output_buffer_load_en (obl),
        .output_buffer_out_en  (obo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: position within the 7N-cycle pass timeline; 0 means idle.
    function automatic logic [11:0] model_out(input int t);
        logic [2:0] ph;
        bit in_rng [7];
        if (t == 0)              ph = 3'd0;
        else if (t <= N)         ph = 3'd1;
        else if (t <= 2*N)       ph = 3'd2;
        else if (t <= 3*N)       ph = 3'd3;
        else if (t <= 6*N - 1)   ph = 3'd4;
        else if (t <= 7*N - 1)   ph = 3'd5;
        else                     ph = 3'd6;
        in_rng[0] = (t >= 1)       && (t <= N);
        in_rng[1] = (t >= N+1)     && (t <= 2*N);
        in_rng[2] = in_rng[1];
        in_rng[3] = (t >= 2*N+1)   && (t <= 3*N);
        in_rng[4] = (t >= 3*N+1)   && (t <= 6*N-1);
        in_rng[5] = (t >= 5*N)     && (t <= 6*N-1);
        in_rng[6] = (t >= 6*N)     && (t <= 7*N-1);
        return {t != 0, t == PASS, ph, in_rng[0], in_rng[1], in_rng[2],
                in_rng[3], in_rng[4], in_rng[5], in_rng[6]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst)                       pass_t = 0;
        else if (pass_t == 0)          pass_t = (start && !abort) ? 1 : 0;
        else if (abort || pass_t == PASS) pass_t = 0;
        else                           pass_t = pass_t + 1;
    end

    always @(negedge clk) begin
        logic [11:0] act;
        logic [6:0]  en;
        cyc++;
        en  = {wbl, wbo, wwe, ibl, ibo, obl, obo};
        act = {busy, done, phase, en};
        check("cycle_compare", int'(act), int'(model_out(pass_t)));
        check("one_load_en", int'(wbl) + int'(ibl) + int'(obl) <= 1, 1);
        check("busy_vs_phase", int'(busy), int'(phase != 3'd0));
        if (done) begin
            check("done_phase", int'(phase), 6);
            check("cnt_wbl", cnt_en[0], N);
            check("cnt_wbo", cnt_en[1], N);
            check("cnt_wwe", cnt_en[2], N);
            check("cnt_ibl", cnt_en[3], N);
            check("cnt_ibo", cnt_en[4], 3*N - 1);
            check("cnt_obl", cnt_en[5], N);
            check("cnt_obo", cnt_en[6], N);
        end
        if (phase == 3'd0) begin
            for (int i = 0; i < 7; i++) cnt_en[i] = 0;
        end else begin
            for (int i = 0; i < 7; i++) cnt_en[i] += int'(en[6-i]);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Pulse start for one edge; returns with the bench in cycle k+1.
    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int n = 1;
        while (!done && n < PASS + 10) begin
            tick();
            n++;
        end
        check(name, n, exp_lat);
    endtask

    initial begin
        // Reset state while rst is held, including across clock edges.
        start = 1'b1;
        abort = 1'b1;
        tick();
        tick();
        check("rst_phase", int'(phase), 0);
        check("rst_outs", int'({busy, done, wbl, wbo, wwe, ibl, ibo, obl, obo}), 0);
        start = 1'b0;
        abort = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        check("idle_after_rst", int'(phase), 0);

        // Nominal pass with stray start pulses during the pass and in DONE.
        kick();
        check("first_wload", int'(phase), 1);
        repeat (8) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("done_latency", PASS - 8 - 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_done_ignored", int'(phase), 0);
        tick();
        check("no_queued_pass", int'(busy), 0);

        // start held: one IDLE cycle between done and next W_LOAD.
        start = 1'b1;
        tick();
        wait_done("b2b_first", PASS);
        tick();
        check("b2b_gap_idle", int'(phase), 0);
        tick();
        check("b2b_restart", int'(phase), 1);
        wait_done("b2b_second", PASS);
        start = 1'b0;
        tick();
        tick();
        check("b2b_stop", int'(busy), 0);

        // Abort during COMPUTE at cycle k+15.
        kick();
        repeat (13) tick();
        check("pre_abort_compute", int'(phase), 4);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", int'(phase), 0);
        check("abort_outs", int'({busy, done, wbl, wbo, wwe, ibl, ibo, obl, obo}), 0);
        repeat (PASS) tick();
        check("abort_no_done", int'(phase), 0);
        kick();
        wait_done("after_abort_latency", PASS);
        tick();

        // abort together with start in IDLE keeps the FSM idle.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_idle", int'(phase), 0);
        tick();

        // Asynchronous reset mid-cycle at k+10.
        kick();
        repeat (9) tick();
        check("pre_rst_aload", int'(phase), 3);
        rst = 1'b1;
        #1;
        check("async_rst_outs", int'({busy, done, phase, wbl, wbo, wwe, ibl, ibo, obl, obo}), 0);
        #1;
        rst = 1'b0;
        tick();
        check("post_rst_phase", int'(phase), 0);
        repeat (PASS + 2) tick();
        check("no_resume", int'(busy), 0);
        kick();
        wait_done("after_rst_latency", PASS);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
